// File: rtl/instr_encoder.sv
// Instruction encoder and program-write engine: packs legal field-level requests
// into MIPS words, buffers them, and streams them to instruction memory.
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        kind_i,
  input  logic [5:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              err_o,
  output logic [15:0]       word_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  headPtr_q, headPtr_d;
  logic [PTR_W-1:0]  tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wordCnt_q, wordCnt_d;
  logic              err_q, err_d;

  logic        isLegal;
  logic [31:0] encWord;
  logic        reqAccept;
  logic        doPush;
  logic        doPop;

  // Legality mirrors exactly what the datapath decoder supports.
  always_comb begin
    isLegal = 1'b0;
    encWord = '0;
    case (kind_i)
      2'd0: begin
        isLegal = (op_i == 6'd0);
        encWord = {6'd0, rs_i, rt_i, rd_i, shamt_i, funct_i};
      end
      2'd1: begin
        isLegal = (op_i == 6'd8) || (op_i == 6'd10) || (op_i == 6'd4);
        encWord = {op_i, rs_i, rt_i, imm_i};
      end
      2'd2: begin
        isLegal = (op_i == 6'd2) || (op_i == 6'd3);
        encWord = {op_i, target_i};
      end
      default: begin
        isLegal = 1'b0;
        encWord = '0;
      end
    endcase
  end

  assign req_ready_o = (count_q < DEPTH_C);
  assign wr_valid_o  = (count_q != '0);
  assign wr_data_o   = mem_q[headPtr_q];
  assign wr_addr_o   = addr_q;
  assign err_o       = err_q;
  assign word_cnt_o  = wordCnt_q;

  assign reqAccept = req_valid_i && req_ready_o;
  assign doPush    = reqAccept && isLegal;
  assign doPop     = wr_valid_o && wr_ready_i;

  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wordCnt_d = wordCnt_q;
    err_d     = reqAccept && !isLegal;
    if (doPush) begin
      tailPtr_d = tailPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      headPtr_d = headPtr_q + PTR_W'(1);
      addr_d    = addr_q + ADDR_W'(4);
      wordCnt_d = wordCnt_q + 16'd1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      wordCnt_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wordCnt_q <= wordCnt_d;
      err_q     <= err_d;
      if (doPush) begin
        mem_q[tailPtr_q] <= encWord;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a vector table feeds both a BASE=0 and a
// wrapping-BASE instance; a scoreboard checks every memory write.
module tb_instr_encoder;

  typedef struct {
    logic [1:0]  kind;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] off;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqValid = 1'b0;
  logic        wrReady = 1'b0;
  logic [1:0]  kind = '0;
  logic [5:0]  op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  logic        reqReady, wrValid, err;
  logic [31:0] wrAddr, wrData;
  logic [15:0] wordCnt;
  logic        reqReady2, wrValid2, err2;
  logic [31:0] wrAddr2, wrData2;
  logic [15:0] wordCnt2;

  int   checks = 0;
  int   errors = 0;
  int   expIdx = 0;
  int   poppedCnt = 0;
  exp_t scoreQ[$];
  exp_t monExp;
  vec_t vecs[12];

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rstN), .req_valid_i(reqValid), .req_ready_o(reqReady),
    .kind_i(kind), .op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
    .funct_i(funct), .imm_i(imm), .target_i(target), .wr_valid_o(wrValid),
    .wr_ready_i(wrReady), .wr_addr_o(wrAddr), .wr_data_o(wrData), .err_o(err),
    .word_cnt_o(wordCnt)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'hFFFF_FFFC)) dutWrap (
    .clk_i(clk), .rst_i(rstN), .req_valid_i(reqValid), .req_ready_o(reqReady2),
    .kind_i(kind), .op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
    .funct_i(funct), .imm_i(imm), .target_i(target), .wr_valid_o(wrValid2),
    .wr_ready_i(wrReady), .wr_addr_o(wrAddr2), .wr_data_o(wrData2), .err_o(err2),
    .word_cnt_o(wordCnt2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic applyStimulus(input vec_t v);
    int  waitCnt = 0;
    bit  seen = 1'b0;
    kind = v.kind; op = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
    shamt = v.shamt; funct = v.funct; imm = v.imm; target = v.target;
    reqValid = 1'b1;
    while (!seen && waitCnt < 200) begin
      @(negedge clk);
      if (reqReady) seen = 1'b1;
      waitCnt++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got ready=0 expected ready=1 within 200 cycles");
      reqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    if (v.legal) begin
      scoreQ.push_back('{off: 32'(expIdx) * 32'd4, data: v.word});
      expIdx++;
    end
    checkOutput("err_after_accept", {31'd0, err}, {31'd0, !v.legal});
    checkOutput("err_wrap_inst", {31'd0, err2}, {31'd0, !v.legal});
  endtask

  task automatic drainWait();
    int n = 0;
    while ((scoreQ.size() != 0 || wrValid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_done", {31'd0, (n < 100)}, 32'd1);
    checkOutput("word_cnt_drained", {16'd0, wordCnt}, 32'(expIdx));
    checkOutput("word_cnt_wrap_inst", {16'd0, wordCnt2}, 32'(expIdx));
  endtask

  // Scoreboard: each write handshake (completing at the next edge) pops one entry.
  always @(negedge clk) begin
    if (rstN) begin
      if (wrValid !== wrValid2) begin
        checkOutput("valid_match", {31'd0, wrValid2}, {31'd0, wrValid});
      end
      if (wrValid && wrReady) begin
        if (scoreQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got data 0x%08h expected no write", wrData);
        end else begin
          monExp = scoreQ.pop_front();
          checkOutput("wr_data", wrData, monExp.data);
          checkOutput("wr_addr", wrAddr, monExp.off);
          checkOutput("wr_data_wrap_inst", wrData2, monExp.data);
          checkOutput("wr_addr_wrap_inst", wrAddr2, monExp.off + 32'hFFFF_FFFC);
          checkOutput("word_cnt_before_write", {16'd0, wordCnt}, 32'(poppedCnt));
          poppedCnt++;
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{2'd1, 6'd8,  5'd0,  5'd8,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0000000, 1'b1, 32'h20080005};
    vecs[1]  = '{2'd0, 6'd0,  5'd8,  5'd9,  5'd10, 5'd0,  6'h20, 16'h0000, 26'h0000000, 1'b1, 32'h01095020};
    vecs[2]  = '{2'd1, 6'd4,  5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0000000, 1'b1, 32'h1022FFFF};
    vecs[3]  = '{2'd2, 6'd2,  5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000100, 1'b1, 32'h08000100};
    vecs[4]  = '{2'd2, 6'd4,  5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000100, 1'b0, 32'h00000000};
    vecs[5]  = '{2'd2, 6'd3,  5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0FFFFFFF};
    vecs[6]  = '{2'd1, 6'd10, 5'd31, 5'd0,  5'd7,  5'd3,  6'h2A, 16'h8000, 26'h3FFFFFF, 1'b1, 32'h2BE08000};
    vecs[7]  = '{2'd0, 6'd0,  5'd0,  5'd5,  5'd6,  5'd31, 6'h00, 16'h1234, 26'h3FFFFFF, 1'b1, 32'h000537C0};
    vecs[8]  = '{2'd1, 6'd35, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'h0010, 26'h0000000, 1'b0, 32'h00000000};
    vecs[9]  = '{2'd0, 6'd8,  5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0000000, 1'b0, 32'h00000000};
    vecs[10] = '{2'd3, 6'd0,  5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000000, 1'b0, 32'h00000000};
    vecs[11] = '{2'd0, 6'd0,  5'd3,  5'd4,  5'd5,  5'd0,  6'h2A, 16'h0000, 26'h0000000, 1'b1, 32'h0064282A};

    // Reset state while held in reset.
    #12;
    checkOutput("reset_req_ready", {31'd0, reqReady}, 32'd1);
    checkOutput("reset_wr_valid", {31'd0, wrValid}, 32'd0);
    checkOutput("reset_wr_addr", wrAddr, 32'h0000_0000);
    checkOutput("reset_wr_addr_wrap_inst", wrAddr2, 32'hFFFF_FFFC);
    checkOutput("reset_wr_data", wrData, 32'h0000_0000);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_word_cnt", {16'd0, wordCnt}, 32'd0);
    #1;
    rstN = 1'b1;
    wrReady = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back stream with the write port always ready.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
    end
    @(posedge clk);
    #1;
    checkOutput("stream_drained_valid", {31'd0, wrValid}, 32'd0);
    checkOutput("stream_word_cnt", {16'd0, wordCnt}, 32'(expIdx));
    checkOutput("stream_err_cleared", {31'd0, err}, 32'd0);

    // Fill the FIFO with the write port stalled; the 5th request must wait.
    wrReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
    end
    checkOutput("full_req_ready", {31'd0, reqReady}, 32'd0);
    fork
      applyStimulus(vecs[5]);
      begin
        repeat (3) @(negedge clk);
        checkOutput("full_still_blocked", {31'd0, reqReady}, 32'd0);
        checkOutput("full_head_stable", wrData, 32'h20080005);
        checkOutput("full_addr_stable", wrAddr, scoreQ[0].off);
        @(posedge clk);
        #1;
        wrReady = 1'b1;
      end
    join
    drainWait();

    // Asynchronous reset with words still buffered.
    wrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i]);
    end
    checkOutput("pre_reset_valid", {31'd0, wrValid}, 32'd1);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'd0, wrValid}, 32'd0);
    checkOutput("async_reset_addr", wrAddr, 32'h0000_0000);
    checkOutput("async_reset_addr_wrap_inst", wrAddr2, 32'hFFFF_FFFC);
    checkOutput("async_reset_ready", {31'd0, reqReady}, 32'd1);
    checkOutput("async_reset_word_cnt", {16'd0, wordCnt}, 32'd0);
    scoreQ.delete();
    expIdx = 0;
    poppedCnt = 0;
    wrReady = 1'b1;
    @(negedge clk);
    #2;
    rstN = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post_reset_no_write", {31'd0, wrValid}, 32'd0);
    checkOutput("post_reset_word_cnt", {16'd0, wordCnt}, 32'd0);

    // Two words after reset: wrap instance must go FFFFFFFC then 0.
    applyStimulus(vecs[3]);
    applyStimulus(vecs[6]);
    drainWait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program-write engine for the single-cycle CPU: the inverse of the opcode decoder. It accepts field-level instruction requests (kind, opcode, register numbers, shamt, funct, immediate, jump target) over a valid/ready handshake. It rejects opcodes the datapath decoder does not support and packs legal requests into 32-bit MIPS words. Legal words are buffered in a small FIFO and written sequentially into instruction memory through a second valid/ready write port with an auto-incrementing byte address.

## Interface
- DEPTH, 4, FIFO depth in words (power of two, ≥2)
- ADDR_W, 32, width of instruction-memory byte address
- BASE_ADDR, 0, first write address after reset

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  encoder can accept a request
- kind_i  in  2  0=R-type, 1=I-type, 2=J-type, 3=illegal
- op_i  in  6  opcode
- rs_i, rt_i, rd_i  in  5 each  register numbers
- shamt_i  in  5  shift amount
- funct_i  in  6  function code
- imm_i  in  16  immediate
- target_i  in  26  jump target
- wr_valid_o  out  1  word available to write
- wr_ready_i  in  1  memory accepts the write
- wr_addr_o  out  ADDR_W  byte address of current word
- wr_data_o  out  32  encoded instruction word
- err_o  out  1  one-cycle pulse: previous accepted request was rejected
- word_cnt_o  out  16  total words written since reset

## Operation
- Legality: kind 0 requires op=0; kind 1 requires op ∈ {8 addi, 10 slti, 4 beq}; kind 2 requires op ∈ {2, 3}; kind 3 is always illegal.
- Encoding: R = {6'd0, rs, rt, rd, shamt, funct}; I = {op, rs, rt, imm}; J = {op, target}. Fields unused by a kind are ignored.
- Accept: req_valid_i && req_ready_o at a rising edge.
- Legal accepted word is pushed to the FIFO tail.
- Illegal accepted word is dropped, nothing is pushed, and err_o=1 for the following cycle only.
- req_ready_o = (count < DEPTH), combinational from the registered count. Depends on no input, so there is no combinational path from wr_ready_i.
- Write side: wr_valid_o = (count ≠ 0); wr_data_o = FIFO head; wr_addr_o = address register.
- On wr_valid_o && wr_ready_i: pop the head, address += 4 (modulo 2^ADDR_W, wraps silently), word_cnt_o += 1 (wraps at 16 bits).
- Simultaneous push and pop: count unchanged, both pointers advance. Legal because ready is based on pre-edge count.
- Push when full cannot occur, since ready=0. Pop when empty cannot occur, since valid=0. Both pointers wrap modulo DEPTH.
- wr_valid_o stays high and wr_data_o/wr_addr_o stay stable until accepted. This does not depend on wr_ready_i.

## Timing
- Reset (rst_i=0, asynchronous): count=0, pointers=0, address=BASE_ADDR, word_cnt_o=0, err_o=0.
- Outputs during and after reset: req_ready_o=1 (DEPTH>0), wr_valid_o=0, wr_addr_o=BASE_ADDR, wr_data_o=don't-care (implementation drives 0 from cleared storage).
- Reset mid-transfer discards all buffered words; there is no partial write.
- Latency: a legal request accepted at edge N gives wr_valid_o=1 with that word from just after edge N, if the FIFO was empty.
- Sustained throughput: one word per cycle when req_valid_i and wr_ready_i are held high.
- err_o is asserted for exactly one cycle after the edge that accepted the illegal request. Back-to-back illegal requests hold it high one cycle each, continuously.
- FIFO full: req_ready_o drops just after the edge that fills it. It rises just after the first pop edge.

## Test plan
- Reset then addi rs=0 rt=8 imm=5, wr_ready_i=1 → wr_data_o=0x20080005 at wr_addr_o=BASE_ADDR; word_cnt_o=1 after the write edge.
- Stream R add (rs=8, rt=9, rd=10, funct=0x20), beq (rs=1, rt=2, imm=0xFFFF), j (target=0x100) → words 0x01095020, 0x1022FFFF, 0x08000100 at addresses 0, 4, 8 on consecutive cycles.
- wr_ready_i=0, push 5 legal requests with DEPTH=4 → req_ready_o=0 after the 4th accept; the 5th is held. Release wr_ready_i → all 5 words emerge in order and unchanged.
- kind=1 op=35, then kind=0 op=8, then kind=3 → each accepted, err_o pulses once per request, no FIFO push, word_cnt_o unchanged.
- BASE_ADDR=2^ADDR_W−4, write 2 words → addresses 0xFFFFFFFC then 0x00000000.
- Assert rst_i=0 asynchronously with 3 words buffered → wr_valid_o=0 and wr_addr_o=BASE_ADDR immediately with no clock edge; no write occurs after release.
